fetch_stage: RTL and testbench

Producer side of the fetch→instruction-queue interface. Holds the fetch PC, issues one instruction-cache request at a time, and attaches branch-predictor results plus predecoded branch class to each fetched instruction. Presents one `INST_Q` per cycle through `fetch_en` / `if_inst_out`, and obeys the queue's `inst_queue_full` back-pressure. On `branch_incorrect` it redirects to the resolved target and discards any stale cache response.

---
 rtl/fetch_stage_pkg.sv | 51 +++++
 rtl/fetch_stage_predecode.sv | 29 ++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage_pkg: shared types and constants for the fetch stage.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam int OBQ_SIZE = 16;
  localparam int BR_IDX_W = $clog2(OBQ_SIZE);

  localparam logic [31:0] NOOP_INST = 32'h47ff_041f;

  localparam logic [5:0] BR_OP  = 6'h30;
  localparam logic [5:0] BSR_OP = 6'h34;
  localparam logic [5:0] JMP_OP = 6'h1a;
  // Conditional branches occupy 0x38..0x3f: top three opcode bits set.
  localparam logic [2:0] CBR_PREFIX = 3'b111;

  typedef struct packed {
    logic                en;
    logic                cond;
    logic                direct;
    logic                ret;
    logic [63:0]         pc;
    logic [63:0]         pred_pc;
    logic                prediction;
    logic [BR_IDX_W-1:0] br_idx;
  } BRANCH_INST;

  typedef struct packed {
    logic [31:0] ir;
    logic [63:0] npc;
    logic        valid_inst;
    BRANCH_INST  branch_inst;
  } INST_Q;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  function automatic INST_Q empty_inst();
    INST_Q r;
    r    = '0;
    r.ir = NOOP_INST;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_predecode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | predecode: classifies an instruction word by branch type.          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module predecode
  import fetch_stage_pkg::*;
(
  input  logic [31:0] ir,
  output logic        en,
  output logic        cond,
  output logic        direct,
  output logic        ret
);

  logic [5:0] op;
  logic       is_jmp;

  always_comb begin
    op     = ir[31:26];
    cond   = (op[5:3] == CBR_PREFIX);
    direct = cond | (op == BR_OP) | (op == BSR_OP);
    is_jmp = (op == JMP_OP);
    ret    = is_jmp & (ir[15:14] == 2'b10);
    en     = direct | is_jmp;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage: PC, I-cache request FSM, output/skid registers.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inst_queue_full,
  input  logic                branch_incorrect,
  input  logic [63:0]         branch_target,
  input  logic                Icache2proc_valid,
  input  logic [63:0]         Icache2proc_data,
  input  logic                bp_pred_taken,
  input  logic [63:0]         bp_pred_pc,
  input  logic [BR_IDX_W-1:0] bp_br_idx,
  output logic                proc2Icache_req,
  output logic [63:0]         proc2Icache_addr,
  output logic                fetch_en,
  output INST_Q               if_inst_out
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  drop_addr_q, drop_addr_d;
  INST_Q        out_q, out_d;
  INST_Q        skid_q, skid_d;
  logic         req_prev_q, req_prev_d;

  logic         req;
  logic         xfer;
  logic         out_free;
  logic [31:0]  fetched_ir;
  logic         pd_en, pd_cond, pd_direct, pd_ret;
  INST_Q        fetched;

  assign fetched_ir = pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];

  predecode u_predecode (
    .ir     (fetched_ir),
    .en     (pd_en),
    .cond   (pd_cond),
    .direct (pd_direct),
    .ret    (pd_ret)
  );

  always_comb begin
    fetched                        = '0;
    fetched.ir                     = fetched_ir;
    fetched.npc                    = pc_q + 64'd4;
    fetched.valid_inst             = 1'b1;
    fetched.branch_inst.en         = pd_en;
    fetched.branch_inst.cond       = pd_cond;
    fetched.branch_inst.direct     = pd_direct;
    fetched.branch_inst.ret        = pd_ret;
    fetched.branch_inst.pc         = pc_q;
    fetched.branch_inst.prediction = pd_en & bp_pred_taken;
    fetched.branch_inst.pred_pc    = (pd_en & bp_pred_taken) ? bp_pred_pc : pc_q + 64'd4;
    fetched.branch_inst.br_idx     = bp_br_idx;
  end

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    drop_addr_d      = drop_addr_q;
    out_d            = out_q;
    skid_d           = skid_q;
    req              = 1'b0;
    proc2Icache_addr = pc_q;

    xfer     = out_q.valid_inst & ~inst_queue_full;
    out_free = ~out_q.valid_inst | ~inst_queue_full;

    if (xfer) out_d.valid_inst = 1'b0;

    case (state_q)
      FETCH: begin
        // A request raised last cycle keeps going even if out has since blocked.
        req = out_free | req_prev_q;
        if (req && Icache2proc_valid) begin
          pc_d = fetched.branch_inst.pred_pc;
          if (out_free) begin
            out_d = fetched;
          end else begin
            skid_d  = fetched;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          out_d   = skid_q;
          skid_d  = empty_inst();
          state_d = FETCH;
        end
      end
      DROP: begin
        req              = 1'b1;
        proc2Icache_addr = drop_addr_q;
        if (Icache2proc_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (branch_incorrect) begin
      out_d  = empty_inst();
      skid_d = empty_inst();
      pc_d   = branch_target;
      if (state_q == DROP) begin
        state_d = DROP;
      end else if (req && !Icache2proc_valid) begin
        state_d     = DROP;
        drop_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end

    proc2Icache_req = req & reset;
    req_prev_d      = proc2Icache_req;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      out_q       <= empty_inst();
      skid_q      <= empty_inst();
      req_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      req_prev_q  <= req_prev_d;
    end
  end

  assign fetch_en    = out_q.valid_inst;
  assign if_inst_out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_stage: directed self-checking bench for fetch_stage.      |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                inst_queue_full;
  logic                branch_incorrect;
  logic [63:0]         branch_target;
  logic                Icache2proc_valid;
  logic [63:0]         Icache2proc_data;
  logic                bp_pred_taken;
  logic [63:0]         bp_pred_pc;
  logic [BR_IDX_W-1:0] bp_br_idx;
  logic                proc2Icache_req;
  logic [63:0]         proc2Icache_addr;
  logic                fetch_en;
  INST_Q               if_inst_out;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage #(.RESET_PC(64'h100)) dut (
    .clock             (clock),
    .reset             (reset),
    .inst_queue_full   (inst_queue_full),
    .branch_incorrect  (branch_incorrect),
    .branch_target     (branch_target),
    .Icache2proc_valid (Icache2proc_valid),
    .Icache2proc_data  (Icache2proc_data),
    .bp_pred_taken     (bp_pred_taken),
    .bp_pred_pc        (bp_pred_pc),
    .bp_br_idx         (bp_br_idx),
    .proc2Icache_req   (proc2Icache_req),
    .proc2Icache_addr  (proc2Icache_addr),
    .fetch_en          (fetch_en),
    .if_inst_out       (if_inst_out)
  );

  always #5 clock = ~clock;

  // Non-branch instruction word tagged with the low bits of its PC.
  function automatic logic [31:0] word(input logic [63:0] pc);
    return 32'h0010_0000 | {16'h0, pc[15:0]};
  endfunction

  function automatic logic [63:0] line(input logic [63:0] pc);
    logic [63:0] a;
    a = {pc[63:3], 3'b000};
    return {word(a + 64'd4), word(a)};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL reset_fetch_en got %b want 0", fetch_en); end
      n_vec++; if (if_inst_out.ir !== NOOP_INST) begin n_err++; $display("FAIL reset_ir got %h want %h", if_inst_out.ir, NOOP_INST); end
      n_vec++; if (proc2Icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", proc2Icache_req); end
    end
    reset = 1'b1;
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", proc2Icache_req); end
    n_vec++; if (proc2Icache_addr !== 64'h100) begin n_err++; $display("FAIL first_addr got %h want 100", proc2Icache_addr); end
  endtask

  task automatic test_streaming();
    logic [63:0] p;
    for (int k = 0; k < 3; k++) begin
      p = 64'h100 + 64'(4 * k);
      Icache2proc_valid = 1'b1;
      Icache2proc_data  = line(p);
      #1;
      n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== p) begin n_err++; $display("FAIL stream_req got %b/%h want 1/%h", proc2Icache_req, proc2Icache_addr, p); end
      @(negedge clock);
      n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== p) begin n_err++; $display("FAIL stream_pc got %b/%h want 1/%h", fetch_en, if_inst_out.branch_inst.pc, p); end
      n_vec++; if (if_inst_out.ir !== word(p)) begin n_err++; $display("FAIL stream_ir got %h want %h", if_inst_out.ir, word(p)); end
      n_vec++; if (if_inst_out.npc !== p + 64'd4) begin n_err++; $display("FAIL stream_npc got %h want %h", if_inst_out.npc, p + 64'd4); end
    end
    Icache2proc_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    inst_queue_full   = 1'b1;
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = line(64'h10c);
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h10c) begin n_err++; $display("FAIL bp_req got %b/%h want 1/10c", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== 64'h108 || if_inst_out.ir !== word(64'h108)) begin n_err++; $display("FAIL bp_stable got %b/%h/%h want 1/108/%h", fetch_en, if_inst_out.branch_inst.pc, if_inst_out.ir, word(64'h108)); end
      n_vec++; if (proc2Icache_req !== 1'b0) begin n_err++; $display("FAIL bp_hold_req got %b want 0", proc2Icache_req); end
      @(negedge clock);
    end
    inst_queue_full = 1'b0;
    #1;
    n_vec++; if (proc2Icache_req !== 1'b0 || if_inst_out.branch_inst.pc !== 64'h108) begin n_err++; $display("FAIL bp_release got %b/%h want 0/108", proc2Icache_req, if_inst_out.branch_inst.pc); end
    @(negedge clock);
    n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== 64'h10c || if_inst_out.ir !== word(64'h10c)) begin n_err++; $display("FAIL bp_skid_out got %b/%h want 1/10c", fetch_en, if_inst_out.branch_inst.pc); end
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = line(64'h110);
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h110) begin n_err++; $display("FAIL bp_resume_req got %b/%h want 1/110", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== 64'h110) begin n_err++; $display("FAIL bp_next got %b/%h want 1/110", fetch_en, if_inst_out.branch_inst.pc); end
    Icache2proc_valid = 1'b0;
  endtask

  task automatic test_predicted_branch();
    #1;
    n_vec++; if (proc2Icache_addr !== 64'h114) begin n_err++; $display("FAIL br_pre_addr got %h want 114", proc2Icache_addr); end
    @(negedge clock);
    n_vec++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL br_drained got %b want 0", fetch_en); end
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = {32'he400_0000, word(64'h110)};
    bp_pred_taken     = 1'b1;
    bp_pred_pc        = 64'h400;
    bp_br_idx         = 4'd5;
    @(negedge clock);
    n_vec++; if (if_inst_out.branch_inst.en !== 1'b1 || if_inst_out.branch_inst.cond !== 1'b1 || if_inst_out.branch_inst.direct !== 1'b1 || if_inst_out.branch_inst.ret !== 1'b0) begin n_err++; $display("FAIL br_class got en%b c%b d%b r%b want 1110", if_inst_out.branch_inst.en, if_inst_out.branch_inst.cond, if_inst_out.branch_inst.direct, if_inst_out.branch_inst.ret); end
    n_vec++; if (if_inst_out.branch_inst.prediction !== 1'b1 || if_inst_out.branch_inst.pred_pc !== 64'h400) begin n_err++; $display("FAIL br_pred got %b/%h want 1/400", if_inst_out.branch_inst.prediction, if_inst_out.branch_inst.pred_pc); end
    n_vec++; if (if_inst_out.branch_inst.br_idx !== 4'd5 || if_inst_out.npc !== 64'h118 || if_inst_out.branch_inst.pc !== 64'h114) begin n_err++; $display("FAIL br_meta got %h/%h/%h want 5/118/114", if_inst_out.branch_inst.br_idx, if_inst_out.npc, if_inst_out.branch_inst.pc); end
    Icache2proc_valid = 1'b0;
    bp_pred_taken     = 1'b0;
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h400) begin n_err++; $display("FAIL br_target_req got %b/%h want 1/400", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = {word(64'h404), 32'h6800_8000};
    bp_pred_pc        = 64'h999;
    bp_br_idx         = 4'd3;
    @(negedge clock);
    n_vec++; if (if_inst_out.branch_inst.en !== 1'b1 || if_inst_out.branch_inst.ret !== 1'b1 || if_inst_out.branch_inst.cond !== 1'b0 || if_inst_out.branch_inst.direct !== 1'b0) begin n_err++; $display("FAIL ret_class got en%b r%b c%b d%b want 1100", if_inst_out.branch_inst.en, if_inst_out.branch_inst.ret, if_inst_out.branch_inst.cond, if_inst_out.branch_inst.direct); end
    n_vec++; if (if_inst_out.branch_inst.prediction !== 1'b0 || if_inst_out.branch_inst.pred_pc !== 64'h404) begin n_err++; $display("FAIL ret_nottaken got %b/%h want 0/404", if_inst_out.branch_inst.prediction, if_inst_out.branch_inst.pred_pc); end
    Icache2proc_valid = 1'b0;
  endtask

  task automatic test_redirect_miss();
    #1;
    n_vec++; if (proc2Icache_addr !== 64'h404) begin n_err++; $display("FAIL rm_seq_addr got %h want 404", proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = {32'hc000_0000, 32'h0};
    bp_pred_taken     = 1'b1;
    bp_pred_pc        = 64'h200;
    @(negedge clock);
    Icache2proc_valid = 1'b0;
    bp_pred_taken     = 1'b0;
    n_vec++; if (if_inst_out.branch_inst.direct !== 1'b1 || if_inst_out.branch_inst.pred_pc !== 64'h200) begin n_err++; $display("FAIL rm_br got %b/%h want 1/200", if_inst_out.branch_inst.direct, if_inst_out.branch_inst.pred_pc); end
    #1;
    n_vec++; if (proc2Icache_addr !== 64'h200) begin n_err++; $display("FAIL rm_req_addr got %h want 200", proc2Icache_addr); end
    @(negedge clock);
    branch_incorrect = 1'b1;
    branch_target    = 64'h800;
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h200) begin n_err++; $display("FAIL rm_flush_req got %b/%h want 1/200", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    branch_incorrect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (fetch_en !== 1'b0 || proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h200) begin n_err++; $display("FAIL rm_drop got %b/%b/%h want 0/1/200", fetch_en, proc2Icache_req, proc2Icache_addr); end
      @(negedge clock);
    end
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = {32'he400_0000, 32'he400_0000};
    bp_pred_taken     = 1'b1;
    bp_pred_pc        = 64'h999;
    #1;
    n_vec++; if (proc2Icache_addr !== 64'h200) begin n_err++; $display("FAIL rm_stale_addr got %h want 200", proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b0;
    bp_pred_taken     = 1'b0;
    #1;
    n_vec++; if (fetch_en !== 1'b0 || proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h800) begin n_err++; $display("FAIL rm_after got %b/%b/%h want 0/1/800", fetch_en, proc2Icache_req, proc2Icache_addr); end
  endtask

  task automatic test_redirect_pending();
    @(negedge clock);
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = line(64'h800);
    @(negedge clock);
    inst_queue_full  = 1'b1;
    Icache2proc_data = line(64'h804);
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'h804) begin n_err++; $display("FAIL rp_skid_req got %b/%h want 1/804", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b0;
    inst_queue_full   = 1'b0;
    branch_incorrect  = 1'b1;
    branch_target     = 64'ha00;
    #1;
    n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== 64'h800 || proc2Icache_req !== 1'b0) begin n_err++; $display("FAIL rp_full got %b/%h/%b want 1/800/0", fetch_en, if_inst_out.branch_inst.pc, proc2Icache_req); end
    @(negedge clock);
    branch_incorrect = 1'b0;
    n_vec++; if (fetch_en !== 1'b0 || if_inst_out.ir !== NOOP_INST) begin n_err++; $display("FAIL rp_cleared got %b/%h want 0/%h", fetch_en, if_inst_out.ir, NOOP_INST); end
    Icache2proc_valid = 1'b1;
    Icache2proc_data  = line(64'ha00);
    #1;
    n_vec++; if (proc2Icache_req !== 1'b1 || proc2Icache_addr !== 64'ha00) begin n_err++; $display("FAIL rp_new_req got %b/%h want 1/a00", proc2Icache_req, proc2Icache_addr); end
    @(negedge clock);
    Icache2proc_valid = 1'b0;
    n_vec++; if (fetch_en !== 1'b1 || if_inst_out.branch_inst.pc !== 64'ha00 || if_inst_out.ir !== word(64'ha00)) begin n_err++; $display("FAIL rp_new_inst got %b/%h/%h want 1/a00/%h", fetch_en, if_inst_out.branch_inst.pc, if_inst_out.ir, word(64'ha00)); end
    @(negedge clock);
    n_vec++; if (fetch_en !== 1'b0) begin n_err++; $display("FAIL rp_no_stale got %b/%h want 0", fetch_en, if_inst_out.branch_inst.pc); end
  endtask

  initial begin
    reset             = 1'b0;
    inst_queue_full   = 1'b0;
    branch_incorrect  = 1'b0;
    branch_target     = '0;
    Icache2proc_valid = 1'b0;
    Icache2proc_data  = '0;
    bp_pred_taken     = 1'b0;
    bp_pred_pc        = '0;
    bp_br_idx         = '0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_predicted_branch();
    test_redirect_miss();
    test_redirect_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
